// File: rtl/ncd_pkg.sv
// Shared definitions for the passcode entry path: state encoding, code geometry
// and a small helper for deriving counter widths.
package ncd_pkg;

   localparam int unsigned DIGIT_W     = 4;
   localparam int unsigned CODE_W      = 16;
   localparam int unsigned CODE_DIGITS = 4;
   localparam int unsigned BCD_MAX     = 9;
   localparam int unsigned CNT_W       = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENTER  = 2'd1,
      CHECK  = 2'd2,
      LOCKED = 2'd3
   } state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/code_timer.sv
// Up-counter with synchronous clear and enable; flags when the count sits at
// the supplied terminal value and holds there rather than wrapping.
module code_timer #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clear,
   input  logic         i_enable,
   input  logic [W-1:0] i_limit,
   output logic         o_done
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count < i_limit)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_done = (r_count == i_limit);

endmodule

// File: rtl/code_entry_ctrl.sv
// Passcode entry controller: gathers four BCD digits from debounced keys,
// compares them with a reference code and locks out after repeated failures.
module code_entry_ctrl
   import ncd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CNT_MAX = 625_000_000,
   parameter int unsigned LOCK_CNT_MAX    = 625_000_000,
   parameter int unsigned MAX_FAIL        = 3
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_clear,
   input  logic               i_confirm,
   input  logic [DIGIT_W-1:0] i_digit,
   input  logic [CODE_W-1:0]  i_ref_code,
   output logic [CODE_W-1:0]  o_entry,
   output logic [CNT_W-1:0]   o_digit_cnt,
   output logic               o_entering,
   output logic               o_match,
   output logic               o_mismatch,
   output logic               o_timeout,
   output logic               o_bad_digit,
   output logic               o_locked
);

   localparam int unsigned TMR_MAX = max_u(TIMEOUT_CNT_MAX, LOCK_CNT_MAX);
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam logic [TMR_W-1:0] TIMEOUT_LIM = TMR_W'(TIMEOUT_CNT_MAX - 1);
   localparam logic [TMR_W-1:0] LOCK_LIM    = TMR_W'(LOCK_CNT_MAX - 1);
   localparam logic [CNT_W-1:0] FAIL_LIM    = CNT_W'(MAX_FAIL);
   localparam logic [CNT_W-1:0] LAST_DIGIT  = CNT_W'(CODE_DIGITS - 1);

   state_e             r_state;
   logic               r_start_q, r_clear_q, r_confirm_q;
   logic [CNT_W-1:0]   r_fail_cnt;
   logic [CODE_W-1:0]  r_entry;
   logic [CNT_W-1:0]   r_digit_cnt;
   logic               r_entering, r_match, r_mismatch, r_timeout, r_bad_digit, r_locked;

   logic               w_start_rise, w_clear_rise, w_confirm_rise, w_digit_ok;
   logic               w_timer_clr, w_timer_en, w_timer_done;
   logic [TMR_W-1:0]   w_timer_lim;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_start_q   <= 1'b0;
         r_clear_q   <= 1'b0;
         r_confirm_q <= 1'b0;
      end else begin
         r_start_q   <= i_start;
         r_clear_q   <= i_clear;
         r_confirm_q <= i_confirm;
      end
   end

   assign w_start_rise   = i_start & ~r_start_q;
   assign w_clear_rise   = i_clear & ~r_clear_q;
   assign w_confirm_rise = i_confirm & ~r_confirm_q;
   assign w_digit_ok     = (i_digit <= DIGIT_W'(BCD_MAX));

   // One timer serves both the entry inactivity limit and the lockout period.
   assign w_timer_en  = (r_state == ENTER) || (r_state == LOCKED);
   assign w_timer_clr = !w_timer_en ||
                        ((r_state == ENTER) && (w_clear_rise || w_confirm_rise));
   assign w_timer_lim = (r_state == LOCKED) ? LOCK_LIM : TIMEOUT_LIM;

   code_timer #(
      .W (TMR_W)
   ) u_timer (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (w_timer_clr),
      .i_enable (w_timer_en),
      .i_limit  (w_timer_lim),
      .o_done   (w_timer_done)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_fail_cnt  <= '0;
         r_entry     <= '0;
         r_digit_cnt <= '0;
         r_entering  <= 1'b0;
         r_match     <= 1'b0;
         r_mismatch  <= 1'b0;
         r_timeout   <= 1'b0;
         r_bad_digit <= 1'b0;
         r_locked    <= 1'b0;
      end else begin
         r_match     <= 1'b0;
         r_mismatch  <= 1'b0;
         r_timeout   <= 1'b0;
         r_bad_digit <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_start_rise) begin
                  r_entry     <= '0;
                  r_digit_cnt <= '0;
                  r_entering  <= 1'b1;
                  r_state     <= ENTER;
               end
            end
            ENTER: begin
               // clear beats confirm; any key activity beats the timeout
               if (w_clear_rise) begin
                  r_entry     <= '0;
                  r_digit_cnt <= '0;
               end else if (w_confirm_rise) begin
                  if (w_digit_ok) begin
                     r_entry     <= {r_entry[CODE_W-DIGIT_W-1:0], i_digit};
                     r_digit_cnt <= r_digit_cnt + 1'b1;
                     if (r_digit_cnt == LAST_DIGIT) begin
                        r_entering <= 1'b0;
                        r_state    <= CHECK;
                     end
                  end else begin
                     r_bad_digit <= 1'b1;
                  end
               end else if (w_timer_done) begin
                  r_timeout   <= 1'b1;
                  r_entry     <= '0;
                  r_digit_cnt <= '0;
                  r_entering  <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            CHECK: begin
               if (r_entry == i_ref_code) begin
                  r_match    <= 1'b1;
                  r_fail_cnt <= '0;
                  r_state    <= IDLE;
               end else begin
                  r_mismatch <= 1'b1;
                  r_fail_cnt <= r_fail_cnt + 1'b1;
                  if ((r_fail_cnt + 1'b1) == FAIL_LIM) begin
                     r_locked <= 1'b1;
                     r_state  <= LOCKED;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            LOCKED: begin
               if (w_timer_done) begin
                  r_fail_cnt <= '0;
                  r_locked   <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_entry     = r_entry;
   assign o_digit_cnt = r_digit_cnt;
   assign o_entering  = r_entering;
   assign o_match     = r_match;
   assign o_mismatch  = r_mismatch;
   assign o_timeout   = r_timeout;
   assign o_bad_digit = r_bad_digit;
   assign o_locked    = r_locked;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Directed bench for code_entry_ctrl: a per-cycle vector table for the basic
// entry path, plus hand-written sequences for lockout, timeout and reset.
module tb_code_entry_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, clear = 1'b0, confirm = 1'b0;
   logic [3:0]  digit = 4'h0;
   logic [15:0] ref_code = 16'h2580;
   logic [15:0] entry;
   logic [2:0]  digit_cnt;
   logic        entering, match, mismatch, timeout, bad_digit, locked;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic        s, c, f;
      logic [3:0]  d;
      logic [15:0] e_entry;
      logic [2:0]  e_cnt;
      logic        e_ent, e_m, e_mm, e_bad;
   } vec_t;

   vec_t vecs[$];

   code_entry_ctrl #(
      .TIMEOUT_CNT_MAX (20),
      .LOCK_CNT_MAX    (30),
      .MAX_FAIL        (3)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_clear     (clear),
      .i_confirm   (confirm),
      .i_digit     (digit),
      .i_ref_code  (ref_code),
      .o_entry     (entry),
      .o_digit_cnt (digit_cnt),
      .o_entering  (entering),
      .o_match     (match),
      .o_mismatch  (mismatch),
      .o_timeout   (timeout),
      .o_bad_digit (bad_digit),
      .o_locked    (locked)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, required finish before 1ms");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] e_entry, input logic [2:0] e_cnt,
                            input logic e_ent, input logic e_m, input logic e_mm,
                            input logic e_to, input logic e_bad, input logic e_lk);
      check({tag, " entry"},     32'(entry),     32'(e_entry));
      check({tag, " digit_cnt"}, 32'(digit_cnt), 32'(e_cnt));
      check({tag, " entering"},  32'(entering),  32'(e_ent));
      check({tag, " match"},     32'(match),     32'(e_m));
      check({tag, " mismatch"},  32'(mismatch),  32'(e_mm));
      check({tag, " timeout"},   32'(timeout),   32'(e_to));
      check({tag, " bad_digit"}, 32'(bad_digit), 32'(e_bad));
      check({tag, " locked"},    32'(locked),    32'(e_lk));
   endtask

   task automatic add(input logic s, input logic c, input logic f, input logic [3:0] d,
                      input logic [15:0] en, input logic [2:0] cnt, input logic ent,
                      input logic m, input logic mm, input logic bad);
      vec_t v;
      v.s = s; v.c = c; v.f = f; v.d = d;
      v.e_entry = en; v.e_cnt = cnt; v.e_ent = ent;
      v.e_m = m; v.e_mm = mm; v.e_bad = bad;
      vecs.push_back(v);
   endtask

   task automatic press(input logic [3:0] d);
      digit = d;
      confirm = 1'b1;
      tick();
      confirm = 1'b0;
      tick();
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   task automatic enter_code(input logic [15:0] code);
      logic [15:0] c;
      c = code;
      do_start();
      for (int k = 3; k >= 0; k--) press(c[k*4 +: 4]);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      check_all("reset", 16'h0, 3'd0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int n;

      // s  c  f  d     entry     cnt ent m mm bad
      add(1, 0, 0, 4'h0, 16'h0000, 0, 1, 0, 0, 0);
      add(0, 0, 1, 4'h2, 16'h0002, 1, 1, 0, 0, 0);
      add(0, 0, 0, 4'h2, 16'h0002, 1, 1, 0, 0, 0);
      add(0, 0, 1, 4'h5, 16'h0025, 2, 1, 0, 0, 0);
      add(0, 0, 0, 4'h5, 16'h0025, 2, 1, 0, 0, 0);
      add(0, 0, 1, 4'h8, 16'h0258, 3, 1, 0, 0, 0);
      add(0, 0, 0, 4'h8, 16'h0258, 3, 1, 0, 0, 0);
      add(0, 0, 1, 4'h0, 16'h2580, 4, 0, 0, 0, 0);
      add(0, 0, 0, 4'h0, 16'h2580, 4, 0, 1, 0, 0);
      add(0, 0, 0, 4'h0, 16'h2580, 4, 0, 0, 0, 0);
      add(0, 0, 1, 4'h7, 16'h2580, 4, 0, 0, 0, 0);
      add(0, 0, 0, 4'h7, 16'h2580, 4, 0, 0, 0, 0);
      add(1, 0, 0, 4'h0, 16'h0000, 0, 1, 0, 0, 0);
      add(0, 0, 1, 4'h2, 16'h0002, 1, 1, 0, 0, 0);
      add(0, 0, 0, 4'h2, 16'h0002, 1, 1, 0, 0, 0);
      add(0, 0, 1, 4'h5, 16'h0025, 2, 1, 0, 0, 0);
      add(0, 0, 0, 4'h5, 16'h0025, 2, 1, 0, 0, 0);
      add(0, 1, 1, 4'h7, 16'h0000, 0, 1, 0, 0, 0);
      add(0, 0, 0, 4'h7, 16'h0000, 0, 1, 0, 0, 0);
      add(0, 0, 1, 4'h3, 16'h0003, 1, 1, 0, 0, 0);
      add(0, 0, 0, 4'h3, 16'h0003, 1, 1, 0, 0, 0);
      add(0, 0, 1, 4'hA, 16'h0003, 1, 1, 0, 0, 1);
      add(0, 0, 1, 4'hA, 16'h0003, 1, 1, 0, 0, 0);
      add(0, 0, 0, 4'hA, 16'h0003, 1, 1, 0, 0, 0);
      add(0, 0, 1, 4'h4, 16'h0034, 2, 1, 0, 0, 0);
      for (int i = 0; i < 9; i++) add(0, 0, 1, 4'h4, 16'h0034, 2, 1, 0, 0, 0);
      add(0, 0, 0, 4'h4, 16'h0034, 2, 1, 0, 0, 0);

      rst_n = 1'b0;
      tick();
      tick();
      check_all("init", 16'h0, 3'd0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) begin
         start = vecs[i].s;
         clear = vecs[i].c;
         confirm = vecs[i].f;
         digit = vecs[i].d;
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].e_entry, vecs[i].e_cnt, vecs[i].e_ent,
                   vecs[i].e_m, vecs[i].e_mm, 1'b0, vecs[i].e_bad, 1'b0);
      end
      confirm = 1'b0;
      do_reset();

      // three wrong codes lock the controller out for 30 cycles
      for (int a = 0; a < 3; a++) begin
         enter_code(16'h1111);
         check($sformatf("lock try%0d mismatch", a), 32'(mismatch), 32'd1);
         check($sformatf("lock try%0d match", a), 32'(match), 32'd0);
         check($sformatf("lock try%0d locked", a), 32'(locked), (a == 2) ? 32'd1 : 32'd0);
      end
      do_start();
      check("locked start ignored entering", 32'(entering), 32'd0);
      check("locked still locked", 32'(locked), 32'd1);
      n = 0;
      while (locked && n < 100) begin
         tick();
         n++;
      end
      check("lock duration", 32'(n), 32'd28);
      enter_code(16'h2580);
      check("after lock match", 32'(match), 32'd1);
      check("after lock entry", 32'(entry), 32'h2580);
      tick();
      check("match one cycle", 32'(match), 32'd0);

      // inactivity timeout
      do_start();
      press(4'h1);
      check("to entry before", 32'(entry), 32'h0001);
      n = 0;
      while (!timeout && n < 100) begin
         tick();
         n++;
      end
      check("timeout latency", 32'(n), 32'd19);
      check_all("timeout", 16'h0, 3'd0, 0, 0, 0, 1, 0, 0);
      tick();
      check("timeout one cycle", 32'(timeout), 32'd0);
      do_start();
      check_all("restart", 16'h0, 3'd0, 1, 0, 0, 0, 0, 0);
      press(4'h5);
      check("restart entry", 32'(entry), 32'h0005);
      do_reset();

      // reset mid-entry must also clear the failure count
      enter_code(16'h1234);
      enter_code(16'h1234);
      check("pre-rst locked", 32'(locked), 32'd0);
      do_start();
      press(4'h1);
      press(4'h2);
      press(4'h3);
      check("mid entry", 32'(entry), 32'h0123);
      check("mid cnt", 32'(digit_cnt), 32'd3);
      do_reset();
      enter_code(16'h9999);
      check("post-rst mismatch", 32'(mismatch), 32'd1);
      check("post-rst not locked", 32'(locked), 32'd0);

      // reset while locked
      enter_code(16'h9999);
      enter_code(16'h9999);
      check("lock again", 32'(locked), 32'd1);
      do_reset();
      check("unlock by reset", 32'(locked), 32'd0);
      enter_code(16'h2580);
      check("final match", 32'(match), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
